// File: rtl/result_dispatcher.sv
// result_dispatcher
//  Return path of the two-slave accelerator: pops one word at a time from the
//  result FIFO and hands it to port 0 or port 1 based on the stored source tag,
//  using a valid/ready handshake. A one-cycle dispatch_cmplt strobe follows the
//  accepted last-of-frame word. An abort flushes the word in flight.
// Optional feature macro: RD_WORD_CNT_EN (adds per-port saturating word counters).
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  i_fifo_empty               result FIFO empty flag
//  o_fifo_rd_en               FIFO pop strobe (data returns one cycle later)
//  i_fifo_rdata/rsrc/rlast    FIFO word, source tag, last-of-frame
//  i_abort                    synchronous flush
//  o_mstrN_valid/data/last    port N word
//  i_mstrN_ready              port N accept
//  o_dispatch_cmplt           one-cycle frame-delivered pulse
//  o_busy                     FSM not in IDLE
//  o_mstrN_cnt                port N delivered words (RD_WORD_CNT_EN only)
module result_dispatcher #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_fifo_empty,
    output logic          o_fifo_rd_en,
    input  logic [DW-1:0] i_fifo_rdata,
    input  logic          i_fifo_rsrc,
    input  logic          i_fifo_rlast,
    input  logic          i_abort,
    output logic          o_mstr0_valid,
    output logic [DW-1:0] o_mstr0_data,
    output logic          o_mstr0_last,
    input  logic          i_mstr0_ready,
    output logic          o_mstr1_valid,
    output logic [DW-1:0] o_mstr1_data,
    output logic          o_mstr1_last,
    input  logic          i_mstr1_ready,
    output logic          o_dispatch_cmplt,
`ifdef RD_WORD_CNT_EN
    output logic [CW-1:0] o_mstr0_cnt,
    output logic [CW-1:0] o_mstr1_cnt,
`endif
    output logic          o_busy
);

    // Parameter sanity check at elaboration time
    if (DW < 1 || CW < 1) begin : g_param_check
        $error("result_dispatcher: DW and CW must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        CMPLT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          src;
        logic          last;
    } word_t;

    state_t r_state;
    state_t w_next_state;
    word_t  r_word;
    word_t  w_word_nxt;
    logic   w_hs;
    logic   w_pres0;
    logic   w_pres1;

    logic          r_rd_en;
    logic          r_m0_valid;
    logic [DW-1:0] r_m0_data;
    logic          r_m0_last;
    logic          r_m1_valid;
    logic [DW-1:0] r_m1_data;
    logic          r_m1_last;
    logic          r_cmplt;
    logic          r_busy;

    // Next-state, word capture and handshake decode; abort overrides everything
    always_comb begin
        w_next_state = r_state;
        w_word_nxt   = r_word;
        w_hs         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_fifo_empty) w_next_state = FETCH;
            end
            FETCH: begin
                w_next_state = CAPTURE;
            end
            CAPTURE: begin
                w_word_nxt   = '{data: i_fifo_rdata, src: i_fifo_rsrc, last: i_fifo_rlast};
                w_next_state = PRESENT;
            end
            PRESENT: begin
                // Only the addressed port's ready matters
                w_hs = r_word.src ? i_mstr1_ready : i_mstr0_ready;
                if (w_hs) begin
                    if (r_word.last)        w_next_state = CMPLT;
                    else if (!i_fifo_empty) w_next_state = FETCH;
                    else                    w_next_state = IDLE;
                end
            end
            CMPLT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (i_abort) begin
            w_next_state = IDLE;
            w_word_nxt   = r_word;
            w_hs         = 1'b0;
        end
        w_pres0 = (w_next_state == PRESENT) && !w_word_nxt.src;
        w_pres1 = (w_next_state == PRESENT) &&  w_word_nxt.src;
    end

    // State, captured word and registered outputs (decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_rd_en    <= 1'b0;
            r_m0_valid <= 1'b0;
            r_m0_data  <= '0;
            r_m0_last  <= 1'b0;
            r_m1_valid <= 1'b0;
            r_m1_data  <= '0;
            r_m1_last  <= 1'b0;
            r_cmplt    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_word     <= w_word_nxt;
            r_rd_en    <= (w_next_state == FETCH);
            r_m0_valid <= w_pres0;
            r_m0_data  <= w_pres0 ? w_word_nxt.data : '0;
            r_m0_last  <= w_pres0 && w_word_nxt.last;
            r_m1_valid <= w_pres1;
            r_m1_data  <= w_pres1 ? w_word_nxt.data : '0;
            r_m1_last  <= w_pres1 && w_word_nxt.last;
            r_cmplt    <= (w_next_state == CMPLT);
            r_busy     <= (w_next_state != IDLE);
        end
    end

`ifdef RD_WORD_CNT_EN
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    // Saturating per-port delivered-word counters; only rst_n clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_hs && !r_word.src && (r_cnt0 != {CW{1'b1}})) r_cnt0 <= r_cnt0 + CW'(1);
            if (w_hs &&  r_word.src && (r_cnt1 != {CW{1'b1}})) r_cnt1 <= r_cnt1 + CW'(1);
        end
    end

    assign o_mstr0_cnt = r_cnt0;
    assign o_mstr1_cnt = r_cnt1;
`endif

    assign o_fifo_rd_en     = r_rd_en;
    assign o_mstr0_valid    = r_m0_valid;
    assign o_mstr0_data     = r_m0_data;
    assign o_mstr0_last     = r_m0_last;
    assign o_mstr1_valid    = r_m1_valid;
    assign o_mstr1_data     = r_m1_data;
    assign o_mstr1_last     = r_m1_last;
    assign o_dispatch_cmplt = r_cmplt;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_result_dispatcher.sv
// Directed bench for result_dispatcher with a small FIFO model that returns
// popped data one cycle after the read strobe.
module tb_result_dispatcher;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_fifo_empty;
    logic          o_fifo_rd_en;
    logic [DW-1:0] i_fifo_rdata = '0;
    logic          i_fifo_rsrc = 1'b0;
    logic          i_fifo_rlast = 1'b0;
    logic          i_abort;
    logic          o_mstr0_valid;
    logic [DW-1:0] o_mstr0_data;
    logic          o_mstr0_last;
    logic          i_mstr0_ready;
    logic          o_mstr1_valid;
    logic [DW-1:0] o_mstr1_data;
    logic          o_mstr1_last;
    logic          i_mstr1_ready;
    logic          o_dispatch_cmplt;
    logic          o_busy;
`ifdef RD_WORD_CNT_EN
    logic [CW-1:0] o_mstr0_cnt;
    logic [CW-1:0] o_mstr1_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: entry = {src, last, data}
    logic [DW+1:0] mem [64];
    logic [5:0]    wr_ptr = '0;
    logic [5:0]    rd_ptr = '0;

    assign i_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (o_fifo_rd_en) begin
            {i_fifo_rsrc, i_fifo_rlast, i_fifo_rdata} <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
        end
    end

    always #5 clk = ~clk;

    result_dispatcher #(.DW(DW), .CW(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_fifo_empty     (i_fifo_empty),
        .o_fifo_rd_en     (o_fifo_rd_en),
        .i_fifo_rdata     (i_fifo_rdata),
        .i_fifo_rsrc      (i_fifo_rsrc),
        .i_fifo_rlast     (i_fifo_rlast),
        .i_abort          (i_abort),
        .o_mstr0_valid    (o_mstr0_valid),
        .o_mstr0_data     (o_mstr0_data),
        .o_mstr0_last     (o_mstr0_last),
        .i_mstr0_ready    (i_mstr0_ready),
        .o_mstr1_valid    (o_mstr1_valid),
        .o_mstr1_data     (o_mstr1_data),
        .o_mstr1_last     (o_mstr1_last),
        .i_mstr1_ready    (i_mstr1_ready),
        .o_dispatch_cmplt (o_dispatch_cmplt),
`ifdef RD_WORD_CNT_EN
        .o_mstr0_cnt      (o_mstr0_cnt),
        .o_mstr1_cnt      (o_mstr1_cnt),
`endif
        .o_busy           (o_busy)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic last, input logic [DW-1:0] data);
        mem[wr_ptr] = {src, last, data};
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    initial begin
        rst_n         = 1'b0;
        i_abort       = 1'b0;
        i_mstr0_ready = 1'b0;
        i_mstr1_ready = 1'b0;

        // Reset state
        step(2);
        chk1("rst_rd_en", o_fifo_rd_en, 1'b0);
        chk1("rst_v0", o_mstr0_valid, 1'b0);
        chk1("rst_v1", o_mstr1_valid, 1'b0);
        chkd("rst_d0", o_mstr0_data, 32'h0);
        chk1("rst_cmplt", o_dispatch_cmplt, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk1("idle_rd_en", o_fifo_rd_en, 1'b0);
        chk1("idle_busy", o_busy, 1'b0);

        // Three words 0,1,0 with last on the third, ready held high
        i_mstr0_ready = 1'b1;
        i_mstr1_ready = 1'b1;
        push(1'b0, 1'b0, 32'hA1A1_0001);
        push(1'b1, 1'b0, 32'hB2B2_0002);
        push(1'b0, 1'b1, 32'hC3C3_0003);
        step(1);
        chk1("f1_rd_en", o_fifo_rd_en, 1'b1);
        chk1("f1_busy", o_busy, 1'b1);
        step(2);
        chk1("w1_v0", o_mstr0_valid, 1'b1);
        chk1("w1_v1", o_mstr1_valid, 1'b0);
        chkd("w1_d0", o_mstr0_data, 32'hA1A1_0001);
        chkd("w1_d1", o_mstr1_data, 32'h0);
        chk1("w1_rd_en", o_fifo_rd_en, 1'b0);
        step(1);
        chk1("hs1_v0", o_mstr0_valid, 1'b0);
        chk1("hs1_rd_en", o_fifo_rd_en, 1'b1);
        step(2);
        chk1("w2_v1", o_mstr1_valid, 1'b1);
        chk1("w2_v0", o_mstr0_valid, 1'b0);
        chkd("w2_d1", o_mstr1_data, 32'hB2B2_0002);
        chk1("w2_l1", o_mstr1_last, 1'b0);
        step(3);
        chk1("w3_v0", o_mstr0_valid, 1'b1);
        chkd("w3_d0", o_mstr0_data, 32'hC3C3_0003);
        chk1("w3_l0", o_mstr0_last, 1'b1);
        chk1("w3_cmplt", o_dispatch_cmplt, 1'b0);
        step(1);
        chk1("cmplt_pulse", o_dispatch_cmplt, 1'b1);
        chk1("cmplt_v0", o_mstr0_valid, 1'b0);
        step(1);
        chk1("cmplt_drop", o_dispatch_cmplt, 1'b0);
        chk1("cmplt_idle", o_busy, 1'b0);

        // Backpressure on port 1 with port 0 ready toggling
        i_mstr1_ready = 1'b0;
        i_mstr0_ready = 1'b0;
        push(1'b1, 1'b0, 32'hDEAD_BEEF);
        step(3);
        for (int i = 0; i < 10; i++) begin
            i_mstr0_ready = ~i_mstr0_ready;
            step(1);
            chk1("hold_v1", o_mstr1_valid, 1'b1);
            chkd("hold_d1", o_mstr1_data, 32'hDEAD_BEEF);
            chk1("hold_v0", o_mstr0_valid, 1'b0);
        end
        i_mstr1_ready = 1'b1;
        step(1);
        chk1("bp_hs_v1", o_mstr1_valid, 1'b0);
        chk1("bp_hs_idle", o_busy, 1'b0);

        // FIFO empty after a non-last handshake, then refill
        i_mstr0_ready = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0011);
        step(1);
        chk1("refill_rd_en", o_fifo_rd_en, 1'b1);
        step(2);
        chk1("refill_v0", o_mstr0_valid, 1'b1);
        chkd("refill_d0", o_mstr0_data, 32'h0000_0011);
        step(1);
        chk1("empty_v0", o_mstr0_valid, 1'b0);
        chk1("empty_idle", o_busy, 1'b0);
        step(1);
        chk1("empty_no_rd", o_fifo_rd_en, 1'b0);

        // Abort on a last word in PRESENT; next word fetched normally
        i_mstr0_ready = 1'b0;
        push(1'b0, 1'b1, 32'h0000_0022);
        push(1'b1, 1'b0, 32'h0000_0033);
        step(3);
        chk1("ab_v0_pre", o_mstr0_valid, 1'b1);
        chk1("ab_l0_pre", o_mstr0_last, 1'b1);
        i_abort       = 1'b1;
        i_mstr0_ready = 1'b1;
        step(1);
        i_abort = 1'b0;
        chk1("ab_v0", o_mstr0_valid, 1'b0);
        chk1("ab_l0", o_mstr0_last, 1'b0);
        chk1("ab_idle", o_busy, 1'b0);
        chk1("ab_cmplt", o_dispatch_cmplt, 1'b0);
        step(1);
        chk1("ab_cmplt2", o_dispatch_cmplt, 1'b0);
        chk1("ab_refetch", o_fifo_rd_en, 1'b1);
        step(2);
        chk1("ab_next_v1", o_mstr1_valid, 1'b1);
        chkd("ab_next_d1", o_mstr1_data, 32'h0000_0033);
        step(1);
        chk1("ab_next_hs", o_mstr1_valid, 1'b0);
        chk1("ab_next_cmplt", o_dispatch_cmplt, 1'b0);

        // Asynchronous reset while presenting
        i_mstr0_ready = 1'b0;
        push(1'b0, 1'b0, 32'h0000_0044);
        step(3);
        chk1("rp_v0_pre", o_mstr0_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rp_v0", o_mstr0_valid, 1'b0);
        chkd("rp_d0", o_mstr0_data, 32'h0);
        chk1("rp_busy", o_busy, 1'b0);
        chk1("rp_rd_en", o_fifo_rd_en, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk1("rp_after_rd_en", o_fifo_rd_en, 1'b0);
        chk1("rp_after_busy", o_busy, 1'b0);

`ifdef RD_WORD_CNT_EN
        // Counter saturation with CW=4
        chkd("cnt0_rst", DW'(o_mstr0_cnt), 32'd0);
        chkd("cnt1_rst", DW'(o_mstr1_cnt), 32'd0);
        i_mstr0_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(1'b0, 1'b0, DW'(i));
        step(70);
        chkd("cnt0_sat", DW'(o_mstr0_cnt), 32'd15);
        chkd("cnt1_zero", DW'(o_mstr1_cnt), 32'd0);
        chk1("cnt_idle", o_busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
